fir_result_fifo: RTL and testbench
==================================

FIR_RESULT_FIFO -- requirements
Module: fir_result_fifo

Interface
REQ-001 Parameter: SHIFT, default 4, right-shift applied to each filter output sample (legal 1..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 y_in  input  16  signed filter output sample (fir_filter y_out).
REQ-005 y_valid  input  1  y_in valid this cycle; there is no back-pressure toward the filter.
REQ-006 d_out  output  8  signed quantized sample at FIFO head.
REQ-007 d_valid  output  1  FIFO non-empty, so d_out is valid.
REQ-008 d_ready  input  1  consumer accepts d_out this cycle.
REQ-009 count  output  4  occupancy, range 0..8.
REQ-010 full  output  1  count == 8.
REQ-011 empty  output  1  count == 0.
REQ-012 overflow  output  1  sticky flag: a sample was dropped.
REQ-013 clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 Quantize each sample: form a 17-bit signed sum y_in + 2^(SHIFT-1), then arithmetic-shift it right by SHIFT (round half up).
REQ-015 Narrow the shifted result to 8 bits per REQ-030/REQ-031.
REQ-016 Storage: 8-entry memory, 3-bit write and read pointers, each wrapping 7->0.
REQ-017 Push occurs when y_valid=1 and (full=0 or pop occurs in the same cycle); the quantized sample is written at wr_ptr, which then increments.
REQ-018 Pop occurs when d_valid=1 and d_ready=1; rd_ptr increments.
REQ-019 d_out is show-ahead: combinationally mem[rd_ptr]; it is don't-care while empty.
REQ-020 count changes +1 on push only, -1 on pop only, and is unchanged on push and pop together.
REQ-021 Full with y_valid=1 and pop: the push is accepted and count stays 8.
REQ-022 Empty with y_valid=1: the sample is written and d_valid rises the next cycle (1-cycle latency from y_valid to d_valid).
REQ-023 Full with y_valid=1 and no pop: the sample is dropped, memory and pointers are unchanged, and overflow is set the next edge.
REQ-024 overflow holds until clear_ovf=1; if a clear and a new drop occur in the same cycle, set wins.
REQ-025 full, empty and d_valid are registered-state derived (from count) and glitch-free relative to clk.

Reset
REQ-026 While reset=0, regardless of clk: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
REQ-027 Reset outputs: d_valid=0, empty=1, full=0, count=0, overflow=0.
REQ-028 Memory contents are not reset.
REQ-029 Reset asserted mid-stream discards all buffered samples; the first push after deassertion lands in entry 0.

Configuration
REQ-030 With macro FIR_RESULT_SAT_EN defined, the shifted value is clamped to [-128,127].
REQ-031 Without FIR_RESULT_SAT_EN, the low 8 bits of the shifted value are kept (two's-complement wrap); there is no clamp logic.

Verification
REQ-032 SHIFT=4, y_in=160 then 167 then 168 with d_ready=1 -> d_out 10, 10, 11, each one cycle after its y_valid.
REQ-033 SHIFT=4, y_in=3000 and y_in=-3000 -> with FIR_RESULT_SAT_EN: 127, -128; without it: -68, 69.
REQ-034 d_ready=0, 9 consecutive y_valid samples 1..9 (pre-shift values 16*k) -> count=8, full=1, overflow=1; draining yields 1..8 in order and the 9th is lost.
REQ-035 Full FIFO, y_valid=1 and d_ready=1 for 4 cycles -> count stays 8, overflow stays 0, and output order is preserved across pointer wrap.
REQ-036 reset pulsed low with count=5 -> count=0, d_valid=0 immediately; the next push appears as the sole entry.
REQ-037 clear_ovf=1 in the same cycle as a drop -> overflow remains 1; clear_ovf alone the next cycle -> 0.

Source files
------------

// File: rtl/fir_result_fifo.sv
// Quantizing 8-deep result FIFO behind the FIR filter: round, shift, narrow, buffer.
// Build option: define FIR_RESULT_SAT_EN to clamp the narrowed sample instead of wrapping.
module fir_result_fifo #(
  parameter int unsigned SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [15:0] y_in,
  input  logic              y_valid,
  output logic signed [7:0] d_out,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [3:0]        count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 17;
  localparam int unsigned ROUND  = 1 << (SHIFT - 1);

  logic signed [SUM_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_q;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_drop;

  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_overflow;

  // Round half up: bias by half an LSB of the shifted result.
  assign w_sum = {y_in[15], y_in} + SUM_W'(ROUND);

`ifdef FIR_RESULT_SAT_EN
  logic signed [SUM_W-1:0] w_shifted;
  assign w_shifted = w_sum >>> SHIFT;
  always_comb begin
    w_q = w_shifted[DATA_W-1:0];
    if (w_shifted > SUM_W'(127))
      w_q = 8'sd127;
    else if (w_shifted < -SUM_W'(128))
      w_q = -8'sd128;
  end
`else
  assign w_q = DATA_W'(w_sum >>> SHIFT);
`endif

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign d_valid  = ~empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign d_out    = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_pop  = d_valid & d_ready;
  assign w_push = y_valid & (~full | w_pop);
  assign w_drop = y_valid & full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A fresh drop outranks a simultaneous clear.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clear_ovf)
        r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_result_fifo.sv
// Directed bench for fir_result_fifo (SHIFT=4) with hand-computed expected values.
module tb_fir_result_fifo;

  logic              clk;
  logic              reset;
  logic signed [15:0] y_in;
  logic              y_valid;
  logic signed [7:0] d_out;
  logic              d_valid;
  logic              d_ready;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clear_ovf;

  int n_cmp;
  int n_err;

  fir_result_fifo #(.SHIFT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    y_in      = '0;
    y_valid   = 1'b0;
    d_ready   = 1'b0;
    clear_ovf = 1'b0;

    // Reset state, before any clock edge
    #3;
    check("rst_count", int'(count), 0);
    check("rst_dvalid", int'(d_valid), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Rounding: 160->10, 167->10, 168->11, each visible one cycle later
    d_ready = 1'b1;
    y_valid = 1'b1;
    y_in = 16'sd160;
    step();
    check("rnd160_dvalid", int'(d_valid), 1);
    check("rnd160", int'(d_out), 10);
    y_in = 16'sd167;
    step();
    check("rnd167", int'(d_out), 10);
    check("rnd167_count", int'(count), 1);
    y_in = 16'sd168;
    step();
    check("rnd168", int'(d_out), 11);
    y_valid = 1'b0;
    step();
    check("rnd_empty", int'(empty), 1);
    check("rnd_dvalid", int'(d_valid), 0);

    // Narrowing of out-of-range values
    d_ready = 1'b0;
    y_valid = 1'b1;
    y_in = 16'sd3000;
    step();
    y_in = -16'sd3000;
    step();
    y_valid = 1'b0;
    check("narrow_count", int'(count), 2);
`ifdef FIR_RESULT_SAT_EN
    check("narrow_pos", int'(d_out), 127);
`else
    check("narrow_pos", int'(d_out), -68);
`endif
    d_ready = 1'b1;
    step();
`ifdef FIR_RESULT_SAT_EN
    check("narrow_neg", int'(d_out), -128);
`else
    check("narrow_neg", int'(d_out), 69);
`endif
    step();
    check("narrow_drained", int'(count), 0);

    // Fill with 1..9, ninth is dropped
    d_ready = 1'b0;
    y_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      y_in = 16'(16 * k);
      step();
    end
    check("fill8_count", int'(count), 8);
    check("fill8_full", int'(full), 1);
    check("fill8_ovf", int'(overflow), 0);
    y_in = 16'sd144;
    step();
    y_valid = 1'b0;
    check("drop_count", int'(count), 8);
    check("drop_ovf", int'(overflow), 1);
    check("drop_head", int'(d_out), 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("clr_ovf", int'(overflow), 0);

    // Full FIFO, push+pop for 4 cycles: occupancy holds, no overflow
    y_valid = 1'b1;
    d_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pp_head", int'(d_out), k + 1);
      y_in = 16'(16 * (10 + k));
      step();
      check("pp_count", int'(count), 8);
    end
    y_valid = 1'b0;
    check("pp_ovf", int'(overflow), 0);

    // Drain across pointer wrap: 5..8 then 10..13, 9 was lost
    for (int k = 0; k < 8; k++) begin
      check("drain", int'(d_out), (k < 4) ? (5 + k) : (6 + k));
      step();
    end
    check("drain_empty", int'(empty), 1);

    // Drop and clear in the same cycle: set wins
    d_ready = 1'b0;
    y_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      y_in = 16'(16 * k);
      step();
    end
    y_in = 16'sd400;
    clear_ovf = 1'b1;
    step();
    y_valid = 1'b0;
    check("setwins_ovf", int'(overflow), 1);
    step();
    clear_ovf = 1'b0;
    check("clr_alone_ovf", int'(overflow), 0);

    // Mid-stream reset with five entries buffered
    d_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check("pre_rst_head", int'(d_out), k);
      step();
    end
    d_ready = 1'b0;
    check("pre_rst_count", int'(count), 5);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_count", int'(count), 0);
    check("midrst_dvalid", int'(d_valid), 0);
    check("midrst_empty", int'(empty), 1);
    @(negedge clk);
    reset = 1'b1;
    y_valid = 1'b1;
    y_in = 16'sd320;
    step();
    y_valid = 1'b0;
    check("post_rst_count", int'(count), 1);
    check("post_rst_head", int'(d_out), 20);
    d_ready = 1'b1;
    step();
    check("post_rst_empty", int'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
